// File: rtl/cpu_types_pkg.sv
// Basic datapath types shared by the CPU blocks.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/mem_request_arbiter_pkg.sv
// Shared state/op encodings and constants for the memory request arbiter.
package mem_arb_pkg;

    import cpu_types_pkg::*;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        INSTR,
        HALTED
    } arb_state_t;

    typedef enum logic {
        MEM_RD,
        MEM_WR
    } mem_op_t;

    // Load data returned when the RAM never acknowledges an access.
    localparam word_t BAD_DATA = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_request_arbiter_if.sv
// Datapath/RAM bundle seen by the arbiter; slave is the arbiter side, master the environment.
interface mem_request_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              halt;
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              ramACK;
    logic [DATA_W-1:0] ramload;
    logic              ihit;
    logic [DATA_W-1:0] iload;
    logic              dhit;
    logic [DATA_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic              halted;
    logic              err;

    modport slave (
        input  halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ramACK, ramload,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, halted, err
    );

    modport master (
        output halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ramACK, ramload,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, halted, err
    );

endinterface

// File: rtl/mem_request_arbiter_wait_counter.sv
// Saturating RAM wait counter; o_terminal flags that MAX_WAIT cycles have elapsed.
module arb_wait_counter #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    logic [CW-1:0] r_count;
    logic          w_terminal;

    assign w_terminal = (r_count == CW'(MAX_WAIT));
    assign o_terminal = w_terminal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_terminal) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/mem_request_arbiter.sv
// Serialises data and instruction requests onto a single-port RAM, data first.
module mem_request_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                 CLK,
    input  logic                 RST,
    mem_request_arbiter_if.slave bus
);

    arb_state_t        r_state;
    arb_state_t        w_nextState;
    mem_op_t           r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_store;
    logic [DATA_W-1:0] r_iload;
    logic [DATA_W-1:0] r_dload;
    logic              r_ihit;
    logic              r_dhit;
    logic              r_err;

    logic w_ramREN;
    logic w_ramWEN;
    logic w_acceptData;
    logic w_acceptInstr;
    logic w_finish;
    logic w_timeout;
    logic w_inAccess;
    logic w_cntClear;
    logic w_timeoutReached;

    // Counter starts from zero on every state entry, so the Nth RAM cycle sees N-1.
    assign w_inAccess = (r_state == DATA) || (r_state == INSTR);
    assign w_cntClear = !w_inAccess || (w_nextState != r_state);

    arb_wait_counter #(
        .MAX_WAIT(MAX_WAIT)
    ) u_waitCounter (
        .clk       (CLK),
        .rst       (RST),
        .i_clear   (w_cntClear),
        .i_enable  (w_inAccess),
        .o_terminal(w_timeoutReached)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_ramREN      = 1'b0;
        w_ramWEN      = 1'b0;
        w_acceptData  = 1'b0;
        w_acceptInstr = 1'b0;
        w_finish      = 1'b0;
        w_timeout     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.halt) begin
                    w_nextState = HALTED;
                end else if (bus.dREN || bus.dWEN) begin
                    w_nextState  = DATA;
                    w_acceptData = 1'b1;
                end else if (bus.iREN) begin
                    w_nextState   = INSTR;
                    w_acceptInstr = 1'b1;
                end
            end
            DATA: begin
                w_ramREN = (r_op == MEM_RD);
                w_ramWEN = (r_op == MEM_WR);
                if (bus.ramACK) begin
                    w_finish    = 1'b1;
                    w_nextState = IDLE;
                end else if (w_timeoutReached) begin
                    w_finish    = 1'b1;
                    w_timeout   = 1'b1;
                    w_nextState = IDLE;
                end
            end
            INSTR: begin
                w_ramREN = 1'b1;
                if (bus.ramACK) begin
                    w_finish    = 1'b1;
                    w_nextState = IDLE;
                end else if (w_timeoutReached) begin
                    w_finish    = 1'b1;
                    w_timeout   = 1'b1;
                    w_nextState = IDLE;
                end
            end
            HALTED: begin
                w_nextState = HALTED;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // A simultaneous read+write request is served as a write and flagged.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_op    <= MEM_RD;
            r_addr  <= '0;
            r_store <= '0;
            r_iload <= '0;
            r_dload <= '0;
            r_ihit  <= 1'b0;
            r_dhit  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ihit <= 1'b0;
            r_dhit <= 1'b0;
            if (w_acceptData) begin
                r_addr  <= bus.daddr;
                r_store <= bus.dstore;
                r_op    <= bus.dWEN ? MEM_WR : MEM_RD;
                if (bus.dREN && bus.dWEN) begin
                    r_err <= 1'b1;
                end
            end else if (w_acceptInstr) begin
                r_addr <= bus.iaddr;
            end
            if (w_finish) begin
                if (r_state == DATA) begin
                    r_dhit <= 1'b1;
                    if (r_op == MEM_RD) begin
                        r_dload <= w_timeout ? DATA_W'(BAD_DATA) : bus.ramload;
                    end
                end else begin
                    r_ihit  <= 1'b1;
                    r_iload <= w_timeout ? DATA_W'(BAD_DATA) : bus.ramload;
                end
                if (w_timeout) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign bus.ihit     = r_ihit;
    assign bus.iload    = r_iload;
    assign bus.dhit     = r_dhit;
    assign bus.dload    = r_dload;
    assign bus.ramREN   = w_ramREN;
    assign bus.ramWEN   = w_ramWEN;
    assign bus.ramaddr  = r_addr;
    assign bus.ramstore = r_store;
    assign bus.halted   = (r_state == HALTED);
    assign bus.err      = r_err;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter: fetch, priority, writes, timeout, halt, reset abort.
module tb_mem_request_arbiter;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   waitCycles;

    mem_request_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_request_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .MAX_WAIT(15)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic h, input logic ir, input logic [31:0] ia,
                                 input logic dr, input logic dw, input logic [31:0] da,
                                 input logic [31:0] ds);
        bus.halt   = h;
        bus.iREN   = ir;
        bus.iaddr  = ia;
        bus.dREN   = dr;
        bus.dWEN   = dw;
        bus.daddr  = da;
        bus.dstore = ds;
    endtask

    task automatic ramReply(input logic ack, input logic [31:0] load);
        bus.ramACK  = ack;
        bus.ramload = load;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        ramReply(0, 0);
        RST = 1'b1;
        tick();
        tick();
        checkOutput("rst_hits", {30'd0, bus.ihit, bus.dhit}, 32'd0);
        checkOutput("rst_loads", bus.iload | bus.dload, 32'd0);
        checkOutput("rst_en", {28'd0, bus.ramREN, bus.ramWEN, bus.halted, bus.err}, 32'd0);
        checkOutput("rst_addr", bus.ramaddr | bus.ramstore, 32'd0);
        RST = 1'b0;

        // Instruction fetch, ACK in first RAM cycle
        applyStimulus(0, 1, 32'h40, 0, 0, 0, 0);
        tick();
        checkOutput("if_ramREN", {31'd0, bus.ramREN}, 32'd1);
        checkOutput("if_ramaddr", bus.ramaddr, 32'h40);
        checkOutput("if_ihit_early", {31'd0, bus.ihit}, 32'd0);
        bus.iREN = 1'b0;
        ramReply(1, 32'h3C010001);
        tick();
        ramReply(0, 0);
        checkOutput("if_ihit", {31'd0, bus.ihit}, 32'd1);
        checkOutput("if_iload", bus.iload, 32'h3C010001);
        checkOutput("if_ramREN_off", {31'd0, bus.ramREN}, 32'd0);
        tick();
        checkOutput("if_ihit_pulse", {31'd0, bus.ihit}, 32'd0);

        // Data before instruction when both arrive together
        applyStimulus(0, 1, 32'h200, 1, 0, 32'h80, 0);
        tick();
        checkOutput("pri_data_addr", bus.ramaddr, 32'h80);
        checkOutput("pri_data_en", {30'd0, bus.ramREN, bus.ramWEN}, 32'b10);
        bus.dREN = 1'b0;
        tick();
        checkOutput("pri_wait_addr", bus.ramaddr, 32'h80);
        tick();
        ramReply(1, 32'hDEADBEEF);
        tick();
        ramReply(0, 0);
        checkOutput("pri_dhit", {30'd0, bus.ihit, bus.dhit}, 32'b01);
        checkOutput("pri_dload", bus.dload, 32'hDEADBEEF);
        tick();
        checkOutput("pri_instr_addr", bus.ramaddr, 32'h200);
        checkOutput("pri_instr_en", {29'd0, bus.ramREN, bus.ramWEN, bus.dhit}, 32'b100);
        bus.iREN = 1'b0;
        ramReply(1, 32'hCAFE0001);
        tick();
        ramReply(0, 0);
        checkOutput("pri_ihit", {30'd0, bus.ihit, bus.dhit}, 32'b10);
        checkOutput("pri_iload", bus.iload, 32'hCAFE0001);
        tick();

        // Write with inputs changing mid-access
        applyStimulus(0, 0, 0, 0, 1, 32'h100, 32'h12345678);
        tick();
        checkOutput("wr_en", {30'd0, bus.ramREN, bus.ramWEN}, 32'b01);
        checkOutput("wr_addr", bus.ramaddr, 32'h100);
        checkOutput("wr_store", bus.ramstore, 32'h12345678);
        applyStimulus(0, 0, 0, 0, 0, 32'h999, 32'hFFFFFFFF);
        tick();
        checkOutput("wr_hold_addr", bus.ramaddr, 32'h100);
        checkOutput("wr_hold_store", bus.ramstore, 32'h12345678);
        checkOutput("wr_hold_en", {31'd0, bus.ramWEN}, 32'd1);
        ramReply(1, 32'h55555555);
        tick();
        ramReply(0, 0);
        checkOutput("wr_dhit", {31'd0, bus.dhit}, 32'd1);
        checkOutput("wr_dload_kept", bus.dload, 32'hDEADBEEF);
        checkOutput("wr_err", {31'd0, bus.err}, 32'd0);
        tick();

        // Read with no ACK: 16 RAM cycles, then aborted hit
        applyStimulus(0, 0, 0, 1, 0, 32'h44, 0);
        tick();
        bus.dREN = 1'b0;
        checkOutput("to_ramREN", {31'd0, bus.ramREN}, 32'd1);
        waitCycles = 0;
        while (!bus.dhit && waitCycles < 40) begin
            tick();
            waitCycles++;
        end
        checkOutput("to_cycles", waitCycles, 32'd16);
        checkOutput("to_dhit", {31'd0, bus.dhit}, 32'd1);
        checkOutput("to_dload", bus.dload, 32'hBAD1BAD1);
        checkOutput("to_err", {31'd0, bus.err}, 32'd1);
        checkOutput("to_idle", {29'd0, bus.ramREN, bus.ramWEN, bus.halted}, 32'd0);
        tick();
        checkOutput("to_err_sticky", {30'd0, bus.err, bus.dhit}, 32'b10);

        // Halt arriving during an access
        applyStimulus(0, 0, 0, 1, 0, 32'h10, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        ramReply(1, 32'h600DF00D);
        tick();
        ramReply(0, 0);
        checkOutput("h_dhit", {30'd0, bus.dhit, bus.halted}, 32'b10);
        checkOutput("h_dload", bus.dload, 32'h600DF00D);
        tick();
        checkOutput("h_halted", {30'd0, bus.halted, bus.dhit}, 32'b10);
        applyStimulus(0, 1, 32'h300, 0, 0, 0, 0);
        ramReply(1, 32'h11111111);
        tick();
        tick();
        checkOutput("h_quiet", {27'd0, bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit, bus.halted}, 32'b00001);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        ramReply(0, 0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checkOutput("h_rst_clear", {30'd0, bus.halted, bus.err}, 32'd0);

        // Reset in the middle of a fetch
        applyStimulus(0, 1, 32'h80, 0, 0, 0, 0);
        tick();
        checkOutput("ra_ramREN", {31'd0, bus.ramREN}, 32'd1);
        bus.iREN = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checkOutput("ra_outs", {29'd0, bus.ramREN, bus.ihit, bus.halted}, 32'd0);
        checkOutput("ra_addr", bus.ramaddr, 32'd0);
        ramReply(1, 32'h77777777);
        tick();
        ramReply(0, 0);
        checkOutput("ra_late_ack", {31'd0, bus.ihit}, 32'd0);
        checkOutput("ra_iload", bus.iload, 32'd0);
        tick();

        // Read and write together: served as a write, flagged
        applyStimulus(0, 0, 0, 1, 1, 32'h20, 32'hA5A5A5A5);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("rw_en", {30'd0, bus.ramREN, bus.ramWEN}, 32'b01);
        checkOutput("rw_err", {31'd0, bus.err}, 32'd1);
        ramReply(1, 32'h99999999);
        tick();
        ramReply(0, 0);
        checkOutput("rw_dhit", {31'd0, bus.dhit}, 32'd1);
        checkOutput("rw_dload", bus.dload, 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_request_arbiter.md
Name: mem_request_arbiter

Overview:
- Responder side of the datapath memory-request interface.
- Accepts the instruction fetch request (iREN) and data requests (dREN/dWEN) that the decoder raises, plus halt, and serialises them onto one single-port RAM.
- Returns one-cycle ihit/dhit pulses with registered load data.
- Sits between the datapath and the RAM model. Data requests have priority over instruction fetches.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data word width.
- MAX_WAIT, 15, RAM wait cycles allowed before an access is aborted as a timeout.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous active-high reset.
- halt  input  1  halt from decode; sampled only in IDLE.
- iREN  input  1  instruction read request.
- iaddr  input  ADDR_W  instruction address.
- dREN  input  1  data read request.
- dWEN  input  1  data write request.
- daddr  input  ADDR_W  data address.
- dstore  input  DATA_W  write data.
- ramACK  input  1  RAM access complete this cycle.
- ramload  input  DATA_W  RAM read data, valid with ramACK.
- ihit  output  1  one-cycle pulse, iload valid.
- iload  output  DATA_W  fetched instruction.
- dhit  output  1  one-cycle pulse, data access done; dload valid for reads.
- dload  output  DATA_W  loaded data.
- ramREN  output  1  RAM read enable.
- ramWEN  output  1  RAM write enable.
- ramaddr  output  ADDR_W  RAM address.
- ramstore  output  DATA_W  RAM write data.
- halted  output  1  arbiter is in HALTED.
- err  output  1  sticky error flag.

Behaviour:
- Reset values (RST high at a rising edge):
  - State goes to IDLE.
  - All outputs 0: ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, halted, err.
  - Wait counter 0.
  - Reset mid-access aborts the access immediately; no hit is produced.
- States: IDLE, DATA, INSTR, HALTED.
- IDLE transitions, priority order:
  - halt=1 -> HALTED.
  - Else dREN or dWEN -> DATA; latch daddr, dstore and op (write if dWEN).
  - Else iREN -> INSTR; latch iaddr.
  - Else stay in IDLE.
- IDLE outputs: ramREN and ramWEN are 0.
- dREN and dWEN both high: treated as a write; err set.
- DATA state:
  - Drive ramaddr and ramstore from the latched values.
  - ramWEN = op write; ramREN = op read.
  - Wait counter increments each cycle.
  - On ramACK: dhit=1 next cycle; dload <= ramload for reads, unchanged for writes; return to IDLE.
- INSTR state:
  - Drive ramREN=1 and ramaddr=latched iaddr.
  - On ramACK: ihit=1 and iload <= ramload next cycle; return to IDLE.
- Latency:
  - Request seen in IDLE at edge 0; RAM enables driven from cycle 1.
  - ACK in cycle k gives the hit in cycle k+1.
  - Minimum request-to-hit is 2 cycles (ACK in the first RAM cycle).
- Hit pulses:
  - ihit and dhit are exactly one cycle wide and never both high.
  - Requests still high in IDLE after a hit are served again; the requester drops or changes them on a hit.
- Request changes mid-access: changes to inputs during DATA/INSTR are ignored because latched values drive the RAM.
- Timeout:
  - The wait counter reaches MAX_WAIT with no ACK -> abort the access.
  - Produce the hit anyway with load data 32'hBAD1BAD1 for reads, set err, return to IDLE.
  - The counter clears on every state entry.
- ramACK outside DATA/INSTR is ignored.
- HALTED:
  - All RAM enables 0, no hits, halted=1.
  - Exit only via RST.
  - An in-flight access always completes before halt is honoured.
- err clears only on RST.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum arb_state_t (IDLE, DATA, INSTR, HALTED);
  - the op enum (MEM_RD, MEM_WR);
  - the timeout pattern constant BAD_DATA = 32'hBAD1BAD1.
- Address and data types come from cpu_types_pkg (word_t).
- One sub-module, arb_wait_counter: a saturating counter with clear, enable, and a terminal flag at MAX_WAIT.
- FSM and datapath registers stay in the top module.

Test Plan:
- iREN=1, iaddr=0x40, ACK in the 1st RAM cycle with ramload=0x3C010001 -> ramREN=1 and ramaddr=0x40 in cycle 1; ihit=1 and iload=0x3C010001 in cycle 2 only.
- iREN=1 and dREN=1 (daddr=0x80) in the same cycle, ACK after 2 waits with ramload=0xDEADBEEF -> data served first with dhit and dload=0xDEADBEEF. Then a second access with ramREN=1, ramaddr=iaddr, ramWEN=0 and ihit.
- dWEN=1, daddr=0x100, dstore=0x12345678, input changed after cycle 1 -> ramWEN=1, ramaddr=0x100, ramstore=0x12345678 held until ACK; dhit pulse; dload unchanged; err=0.
- dREN=1 with ramACK never asserted -> after MAX_WAIT=15 cycles: dhit=1, dload=0xBAD1BAD1, err=1 sticky, state IDLE.
- halt=1 while a DATA access is pending -> access completes with dhit; next cycle halted=1; later iREN gives no ram enables and no hits. RST then clears halted and err.
- RST asserted during INSTR before ACK -> next cycle all outputs 0, no ihit; a later ACK is ignored.
